piso_serializer_ctrl: RTL and testbench

//  Sequencer for a parallel-in/serial-out shift register. Accepts parallel words over a valid/ready

---
 rtl/piso_serializer_ctrl_pkg.sv | 15 +
 rtl/piso_serializer_ctrl_if.sv | 27 ++
 rtl/piso_serializer_ctrl_shift_core.sv | 25 ++
 rtl/piso_serializer_ctrl.sv | 110 +++++++++++
 tb/tb_piso_serializer_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/piso_serializer_ctrl_pkg.sv
// Shared types for the PISO serializer: controller state encoding and counter width helper.
package piso_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Bits needed to count 0..n-1, never less than one so zero-gap builds still elaborate.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_serializer_ctrl_if.sv
// Producer-side word handshake plus serial-side frame signals of the PISO serializer.
interface piso_serializer_ctrl_if #(
  parameter int WIDTH = 4
);
  // Word transfer happens on a rising edge where in_valid && in_ready; a producer holding
  // in_valid keeps in_data stable until then, and in_ready never depends on in_data.
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             bit_tick;
  logic             ser_q;
  logic             ser_valid;
  logic             ser_first;
  logic             ser_last;
  logic             busy;
  logic             done;

  modport master (
    output in_data, in_valid, bit_tick,
    input  in_ready, ser_q, ser_valid, ser_first, ser_last, busy, done
  );

  modport slave (
    input  in_data, in_valid, bit_tick,
    output in_ready, ser_q, ser_valid, ser_first, ser_last, busy, done
  );
endinterface

// File: rtl/piso_serializer_ctrl_shift_core.sv
// Parallel-load, right-shifting register; bit 0 is the serial output. Load wins over shift.
module piso_shift_core #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_q
);
  logic [WIDTH-1:0] r_sreg;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_sreg <= '0;
    end else if (i_load) begin
      r_sreg <= i_d;
    end else if (i_shift) begin
      r_sreg <= {1'b0, r_sreg[WIDTH-1:1]};
    end
  end

  assign o_q = r_sreg[0];
endmodule

// File: rtl/piso_serializer_ctrl.sv
// Serializer sequencer: accepts words, shifts them out LSB-first one bit per bit_tick with
// first/last markers, then optionally idles GAP_CYCLES clocks before the next word.
module piso_serializer_ctrl
  import piso_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  piso_serializer_ctrl_if.slave bus,
  output state_t                o_dbg_state
);
  localparam int BW = cnt_width(WIDTH);
  localparam int GW = cnt_width(GAP_CYCLES + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t          r_state;
  state_t          w_next;
  logic [BW-1:0]   r_bit_cnt;
  logic [GW-1:0]   r_gap_cnt;
  logic            r_done;
  logic            w_ready;
  logic            w_load;
  logic            w_shift;
  logic            w_last_tick;
  logic            w_is_last;
  logic            w_shifting;
  logic            w_core_q;

  assign w_is_last  = (r_bit_cnt == BIT_LAST);
  assign w_shifting = (r_state == ST_SHIFT);

  always_comb begin
    w_next      = r_state;
    w_ready     = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_last_tick = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (bus.in_valid) begin
          w_load = 1'b1;
          w_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bus.bit_tick) begin
          if (!w_is_last) begin
            w_shift = 1'b1;
          end else begin
            w_last_tick = 1'b1;
            // Zero-gap builds reopen the handshake on the final tick so frames abut.
            if (GAP_CYCLES == 0) begin
              w_ready = 1'b1;
              if (bus.in_valid) begin
                w_load = 1'b1;
                w_next = ST_SHIFT;
              end else begin
                w_next = ST_IDLE;
              end
            end else begin
              w_next = ST_GAP;
            end
          end
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == GAP_LAST) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_last_tick;
      if (w_load)       r_bit_cnt <= '0;
      else if (w_shift) r_bit_cnt <= r_bit_cnt + BW'(1);
      if (r_state == ST_GAP) r_gap_cnt <= r_gap_cnt + GW'(1);
      else                   r_gap_cnt <= '0;
    end
  end

  piso_shift_core #(.WIDTH(WIDTH)) u_core (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_d     (bus.in_data),
    .o_q     (w_core_q)
  );

  assign bus.in_ready  = w_ready & Rst_n;
  assign bus.ser_valid = w_shifting;
  assign bus.ser_q     = w_shifting & w_core_q;
  assign bus.ser_first = w_shifting & (r_bit_cnt == '0);
  assign bus.ser_last  = w_shifting & w_is_last;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.done      = r_done;
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_piso_serializer_ctrl.sv
// Bench for piso_serializer_ctrl: three parameterisations (4/1, 4/0, 8/3) driven with directed and
// random words; a per-cycle monitor checks every output against a frame-bit queue model.
module tb_piso_serializer_ctrl;
  import piso_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  piso_serializer_ctrl_if #(.WIDTH(4)) if_a ();
  piso_serializer_ctrl_if #(.WIDTH(4)) if_b ();
  piso_serializer_ctrl_if #(.WIDTH(8)) if_c ();
  state_t dbg_a, dbg_b, dbg_c;

  piso_serializer_ctrl #(.WIDTH(4), .GAP_CYCLES(1)) u_a (
    .Clk(clk), .Rst_n(rst_n), .bus(if_a), .o_dbg_state(dbg_a));
  piso_serializer_ctrl #(.WIDTH(4), .GAP_CYCLES(0)) u_b (
    .Clk(clk), .Rst_n(rst_n), .bus(if_b), .o_dbg_state(dbg_b));
  piso_serializer_ctrl #(.WIDTH(8), .GAP_CYCLES(3)) u_c (
    .Clk(clk), .Rst_n(rst_n), .bus(if_c), .o_dbg_state(dbg_c));

  // ---------------- reference model ----------------
  // Each entry is one expected frame bit: {is_first, is_last, data}.
  logic [2:0] exp_q0[$];
  logic [2:0] exp_q1[$];
  logic [2:0] exp_q2[$];
  int gap_left [3];
  bit done_exp [3];
  int tick_mode[3];

  function automatic int w_of(input int k);
    return (k == 2) ? 8 : 4;
  endfunction

  function automatic int gap_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 0 : 3;
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  task automatic push_word(input int k, input logic [7:0] d);
    logic [2:0] e;
    for (int i = 0; i < w_of(k); i++) begin
      e = {(i == 0), (i == w_of(k) - 1), d[i]};
      case (k)
        0:       exp_q0.push_back(e);
        1:       exp_q1.push_back(e);
        default: exp_q2.push_back(e);
      endcase
    end
  endtask

  task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d t=%0t got=%0h want=%0h", name, k, $time, act, exp);
    end
  endtask

  // act = {ser_valid, ser_first, ser_last, ser_q, in_ready, busy, done}
  task automatic mon(input int k, input bit has, input logic [2:0] h, input logic tick,
                     input logic [6:0] act, input state_t dbg, output bit pop, output bit flush);
    logic e_ready;
    logic e_busy;
    pop   = 1'b0;
    flush = 1'b0;
    if (!rst_n) begin
      chk("reset_outputs", k, {1'b0, act}, 8'h00);
      chk("reset_state", k, {6'b0, dbg}, {6'b0, ST_IDLE});
      gap_left[k] = 0;
      done_exp[k] = 1'b0;
      flush = 1'b1;
    end else begin
      e_ready = (!has && gap_left[k] == 0) || (gap_of(k) == 0 && has && h[1] && tick);
      e_busy  = has || (gap_left[k] > 0);
      chk("ser_valid", k, {7'b0, act[6]}, {7'b0, has});
      chk("ser_first", k, {7'b0, act[5]}, {7'b0, has & h[2]});
      chk("ser_last",  k, {7'b0, act[4]}, {7'b0, has & h[1]});
      chk("ser_q",     k, {7'b0, act[3]}, {7'b0, has & h[0]});
      chk("in_ready",  k, {7'b0, act[2]}, {7'b0, e_ready});
      chk("busy",      k, {7'b0, act[1]}, {7'b0, e_busy});
      chk("done",      k, {7'b0, act[0]}, {7'b0, done_exp[k]});
      done_exp[k] = has && tick && h[1];
      if (gap_left[k] > 0) gap_left[k]--;
      if (has && tick && h[1]) gap_left[k] = gap_of(k);
      pop = has && tick;
    end
  endtask

  // ---------------- monitors (sample on falling edge) ----------------
  always @(negedge clk) begin : mon_a
    bit p, f;
    logic [2:0] h;
    h = (exp_q0.size() > 0) ? exp_q0[0] : 3'b000;
    mon(0, exp_q0.size() > 0, h, if_a.bit_tick,
        {if_a.ser_valid, if_a.ser_first, if_a.ser_last, if_a.ser_q, if_a.in_ready, if_a.busy, if_a.done},
        dbg_a, p, f);
    if (f) exp_q0.delete();
    else if (p) void'(exp_q0.pop_front());
  end

  always @(negedge clk) begin : mon_b
    bit p, f;
    logic [2:0] h;
    h = (exp_q1.size() > 0) ? exp_q1[0] : 3'b000;
    mon(1, exp_q1.size() > 0, h, if_b.bit_tick,
        {if_b.ser_valid, if_b.ser_first, if_b.ser_last, if_b.ser_q, if_b.in_ready, if_b.busy, if_b.done},
        dbg_b, p, f);
    if (f) exp_q1.delete();
    else if (p) void'(exp_q1.pop_front());
  end

  always @(negedge clk) begin : mon_c
    bit p, f;
    logic [2:0] h;
    h = (exp_q2.size() > 0) ? exp_q2[0] : 3'b000;
    mon(2, exp_q2.size() > 0, h, if_c.bit_tick,
        {if_c.ser_valid, if_c.ser_first, if_c.ser_last, if_c.ser_q, if_c.in_ready, if_c.busy, if_c.done},
        dbg_c, p, f);
    if (f) exp_q2.delete();
    else if (p) void'(exp_q2.pop_front());
  end

  // ---------------- tick generators ----------------
  // mode 0: random, mode m>0: one tick every m clocks.
  function automatic logic tick_val(input int m, input int ph);
    if (m == 0) return 1'($urandom_range(0, 1));
    return (ph % m) == 0;
  endfunction

  initial begin
    int ph = 0;
    if_a.bit_tick = 1'b1;
    forever begin @(posedge clk); #1; ph++; if_a.bit_tick = tick_val(tick_mode[0], ph); end
  end
  initial begin
    int ph = 0;
    if_b.bit_tick = 1'b1;
    forever begin @(posedge clk); #1; ph++; if_b.bit_tick = tick_val(tick_mode[1], ph); end
  end
  initial begin
    int ph = 0;
    if_c.bit_tick = 1'b1;
    forever begin @(posedge clk); #1; ph++; if_c.bit_tick = tick_val(tick_mode[2], ph); end
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input int k, input logic [7:0] d, input logic v);
    case (k)
      0:       begin if_a.in_data = d[3:0]; if_a.in_valid = v; end
      1:       begin if_b.in_data = d[3:0]; if_b.in_valid = v; end
      default: begin if_c.in_data = d;      if_c.in_valid = v; end
    endcase
  endtask

  function automatic logic get_ready(input int k);
    case (k)
      0:       return if_a.in_ready;
      1:       return if_b.in_ready;
      default: return if_c.in_ready;
    endcase
  endfunction

  // Presents a word until accepted; returns at posedge+1 of the accepting edge.
  task automatic send(input int k, input logic [7:0] d, input bit keep);
    bit hs;
    int n = 0;
    set_in(k, d, 1'b1);
    do begin
      @(negedge clk);
      hs = (get_ready(k) === 1'b1);
      @(posedge clk); #1;
      n++;
    end while (!hs && n < 300);
    if (hs) push_word(k, d);
    else begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout dut%0d t=%0t got=no_accept want=accept", k, $time);
    end
    if (!keep) set_in(k, d, 1'b0);
  endtask

  // Random in_valid pulses; anything the DUT does accept enters the model as a real word.
  task automatic junk(input int k, input int ncyc);
    logic [7:0] d;
    logic v;
    bit hs;
    for (int i = 0; i < ncyc; i++) begin
      d = 8'($urandom);
      v = 1'($urandom_range(0, 1));
      set_in(k, d, v);
      @(negedge clk);
      hs = v && (get_ready(k) === 1'b1);
      @(posedge clk); #1;
      if (hs) push_word(k, d);
    end
    set_in(k, 8'h00, 1'b0);
  endtask

  task automatic drain(input int k);
    int n = 0;
    @(posedge clk);
    while ((qsize(k) > 0 || gap_left[k] > 0) && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 500) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout dut%0d t=%0t got=busy want=idle", k, $time);
    end
  endtask

  task automatic idle_gap();
    int n;
    n = $urandom_range(0, 3);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick_mode[k] = 1;
      set_in(k, 8'h00, 1'b0);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single word at full rate, then reset in the middle of a frame and resume cleanly.
    send(0, 8'h0B, 1'b0);
    drain(0);
    send(0, 8'h06, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(0, 8'h0B, 1'b0);
    drain(0);

    // Slow tick, then valid pulses while busy, then random traffic.
    tick_mode[0] = 3;
    send(0, 8'h06, 1'b0);
    drain(0);
    tick_mode[0] = 1;
    send(0, 8'($urandom), 1'b0);
    junk(0, 8);
    drain(0);
    send(0, 8'h03, 1'b0);
    drain(0);
    tick_mode[0] = 0;
    for (int i = 0; i < 15; i++) begin
      idle_gap();
      send(0, 8'($urandom), 1'b0);
    end
    junk(0, 20);
    drain(0);

    // Back-to-back frames with in_valid held high.
    send(1, 8'h0A, 1'b1);
    send(1, 8'h05, 1'b0);
    drain(1);
    tick_mode[1] = 0;
    for (int i = 0; i < 12; i++) send(1, 8'($urandom), 1'b1);
    set_in(1, 8'h00, 1'b0);
    junk(1, 20);
    drain(1);

    // Wide word with a three-clock gap before the next accept.
    send(2, 8'h81, 1'b1);
    send(2, 8'h3C, 1'b0);
    drain(2);
    tick_mode[2] = 0;
    for (int i = 0; i < 6; i++) begin
      idle_gap();
      send(2, 8'($urandom), 1'b0);
    end
    junk(2, 20);
    drain(2);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    n_bad++;
    $display("FAIL watchdog t=%0t got=running want=finished", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
